// File: rtl/seq_tx_if.sv
// Handshake bundle for seq_tx: request/pattern inputs and serial-stream outputs.
// The master drives requests and the slave (seq_tx) drives the stream.
interface seq_tx_if;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [1:0] rpt;
  logic       ready;
  logic       x;
  logic       x_valid;
  logic       done;

  modport master (
    output start, pattern, len, rpt,
    input  ready, x, x_valid, done
  );

  modport slave (
    input  start, pattern, len, rpt,
    output ready, x, x_valid, done
  );
endinterface

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends pattern[len:0] MSB-first, rpt+1 times with GAP idle
// cycles between frames. Optional macro SEQ_TX_PARITY_EN appends an even-parity bit per frame.
module seq_tx #(
  parameter int GAP = 2
) (
  input  logic     clk,
  input  logic     clr,
  seq_tx_if.slave  bus
);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_GAP, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;
`endif

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] rep_q, rep_d;
  logic [3:0] gap_q, gap_d;
  logic       x_q, x_d;
  logic       x_valid_q, x_valid_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       frame_end;

`ifdef SEQ_TX_PARITY_EN
  logic [7:0] len_mask;
  logic       par_bit;

  // Only bits at or below len take part in the parity.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign len_mask[gi] = (3'(gi) <= len_q);
  end
  assign par_bit = ^(pat_q & len_mask);
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;

`ifdef SEQ_TX_PARITY_EN
    frame_end = (state_q == ST_PAR);
`else
    frame_end = (state_q == ST_SHIFT) && (bit_q == 3'd0);
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          pat_d   = bus.pattern;
          len_d   = bus.len;
          bit_d   = bus.len;
          rep_d   = bus.rpt;
        end
      end
      ST_SHIFT: begin
        if (bit_q != 3'd0) begin
          bit_d = bit_q - 3'd1;
        end
`ifdef SEQ_TX_PARITY_EN
        else begin
          state_d = ST_PAR;
        end
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: ;
`endif
      ST_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else begin
          state_d = ST_SHIFT;
          bit_d   = len_q;
          if (rep_q != 2'd0) rep_d = rep_q - 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Last cycle of a frame decides between another repetition and finishing.
    if (frame_end) begin
      if (rep_q != 2'd0) begin
        if (GAP == 0) begin
          state_d = ST_SHIFT;
          bit_d   = len_q;
          rep_d   = rep_q - 2'd1;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LAST;
        end
      end else begin
        state_d = ST_DONE;
      end
    end

    // Outputs are decoded from the next state so they can be registered with it.
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        x_d       = pat_d[bit_d];
        x_valid_d = 1'b1;
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        x_d       = par_bit;
        x_valid_d = 1'b1;
      end
`endif
      default: ;
    endcase
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      pat_q     <= 8'd0;
      len_q     <= 3'd0;
      bit_q     <= 3'd0;
      rep_q     <= 2'd0;
      gap_q     <= 4'd0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Randomized bench for seq_tx: two instances (GAP=2 and GAP=0) share the same stimulus and
// are compared cycle by cycle against a frame-level reference stream built from the rules.
module tb_seq_tx;
  typedef struct packed {
    logic x;
    logic xv;
    logic dn;
    logic rdy;
  } obs_t;

  localparam obs_t IDLE_OBS = 4'b0001;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [1:0] rpt;

  seq_tx_if bus2();
  seq_tx_if bus0();

  assign bus2.start   = start;
  assign bus2.pattern = pattern;
  assign bus2.len     = len;
  assign bus2.rpt     = rpt;
  assign bus0.start   = start;
  assign bus0.pattern = pattern;
  assign bus0.len     = len;
  assign bus0.rpt     = rpt;

  seq_tx #(.GAP(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));
  seq_tx #(.GAP(0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[2][$];
  int   gaps[2] = '{2, 0};

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got x/xv/done/ready=%b required %b", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int d);
    if (d == 0) return {bus2.x, bus2.x_valid, bus2.done, bus2.ready};
    return {bus0.x, bus0.x_valid, bus0.done, bus0.ready};
  endfunction

  // Expected per-cycle stream after acceptance: frames, gaps, done pulse, then one idle cycle.
  task automatic build_exp(input int d, input logic [7:0] pat, input int l, input int r);
    logic p;
    exp_q[d].delete();
    for (int rep = 0; rep <= r; rep++) begin
      p = 1'b0;
      for (int b = l; b >= 0; b--) begin
        exp_q[d].push_back({pat[b], 1'b1, 1'b0, 1'b0});
        p ^= pat[b];
      end
`ifdef SEQ_TX_PARITY_EN
      exp_q[d].push_back({p, 1'b1, 1'b0, 1'b0});
`endif
      if (rep < r)
        for (int g = 0; g < gaps[d]; g++) exp_q[d].push_back(4'b0000);
    end
    exp_q[d].push_back(4'b0010);
    exp_q[d].push_back(IDLE_OBS);
  endtask

  task automatic load(input logic [7:0] pat, input logic [2:0] l, input logic [1:0] r);
    start   = 1'b1;
    pattern = pat;
    len     = l;
    rpt     = r;
    for (int d = 0; d < 2; d++) build_exp(d, pat, int'(l), int'(r));
  endtask

  task automatic accept(input logic [7:0] pat, input logic [2:0] l, input logic [1:0] r);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("pre_ready dut%0d", d), sample(d), IDLE_OBS);
    load(pat, l, r);
    $display("[TB] tx pattern=%h len=%0d rpt=%0d", pat, l, r);
    @(posedge clk);
  endtask

  // mode 0: start low; 1: random stray starts while busy; 2: hold start high throughout
  task automatic play(input int mode, input string tag);
    int n, m;
    n = (exp_q[0].size() > exp_q[1].size()) ? exp_q[0].size() : exp_q[1].size();
    m = (exp_q[0].size() < exp_q[1].size()) ? exp_q[0].size() : exp_q[1].size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check($sformatf("%s[%0d] dut%0d", tag, i, d), sample(d),
              (i < exp_q[d].size()) ? exp_q[d][i] : IDLE_OBS);
      pattern = 8'($urandom);
      len     = 3'($urandom);
      rpt     = 2'($urandom);
      if (mode == 2)                     start = 1'b1;
      else if (mode == 1 && i < m - 1)   start = 1'($urandom_range(0, 1));
      else                               start = 1'b0;
    end
  endtask

  initial begin
    start = 1'b0; pattern = 8'd0; len = 3'd0; rpt = 2'd0;
    clr = 1'b0;
    load(8'hA5, 3'd7, 2'd0);
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check($sformatf("reset dut%0d", d), sample(d), IDLE_OBS);
    end
    clr = 1'b1;
    @(posedge clk);
    play(0, "req028");

    accept(8'hFF, 3'd2, 2'd2);  play(0, "req029");
    accept(8'h06, 3'd2, 2'd1);  play(1, "req030");
    accept(8'h0B, 3'd3, 2'd0);  play(0, "len3");
    accept(8'h0B, 3'd1, 2'd0);  play(1, "len1");

    // Reset on the 4th shift cycle, start held through reset.
    accept(8'hA5, 3'd7, 2'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        check($sformatf("pre_clr[%0d] dut%0d", i, d), sample(d), exp_q[d][i]);
      start = 1'b0;
    end
    clr = 1'b0; start = 1'b1; pattern = 8'h3C;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("mid_clr dut%0d", d), sample(d), IDLE_OBS);
    clr = 1'b1;
    load(8'hC3, 3'd5, 2'd0);
    $display("[TB] clr released with start held, pattern=c3 len=5");
    @(posedge clk);
    play(0, "after_clr");

    // Start held high across DONE: accepted on the first IDLE edge.
    accept(8'h5A, 3'd4, 2'd0);
    play(2, "hold_a");
    load(8'h81, 3'd7, 2'd0);
    @(posedge clk);
    play(0, "hold_b");

    for (int t = 0; t < 40; t++) begin
      accept(8'($urandom), 3'($urandom), 2'($urandom));
      play(1, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter GAP, default 2: idle cycles between repetitions, legal range 0..15.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 clr  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-004 start  input  1  transmit request, qualified by ready.
REQ-005 pattern  input  8  bit pattern to send.
REQ-006 len  input  3  number of bits to send minus 1 (0 -> 1 bit, 7 -> 8 bits).
REQ-007 rpt  input  2  extra repetitions (0 -> send once, 3 -> send 4 times).
REQ-008 ready  output  1  block idle and able to accept start.
REQ-009 x  output  1  serial data bit, the stream consumed by the team's sequence-detector FSM.
REQ-010 x_valid  output  1  x carries a frame bit this cycle.
REQ-011 done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-012 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-013 States SHALL be IDLE, SHIFT, PAR, GAP and DONE; PAR exists only per REQ-027.
REQ-014 In IDLE, ready=1, x=0, x_valid=0, done=0.
REQ-015 On a rising edge with ready=1 and start=1, the block SHALL latch pattern, len and rpt, load bit counter = len and rep counter = rpt, and enter SHIFT; ready=0 from the next cycle.
REQ-016 start with ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-017 First SHIFT cycle (one cycle after acceptance): x = pattern[len], x_valid=1. Send MSB-first down to pattern[0], one bit per cycle, len+1 cycles per frame.
REQ-018 Bits above pattern[len] SHALL never be transmitted.
REQ-019 After bit 0: go to PAR if compiled in; else if rep counter > 0 go to GAP (or, with GAP=0, directly to SHIFT at bit len with the counter decremented); else go to DONE.
REQ-020 GAP SHALL last exactly GAP cycles with x=0 and x_valid=0, then re-enter SHIFT at bit len with the rep counter decremented by 1.
REQ-021 Total frames sent = rpt+1; each frame SHALL use the latched pattern and ignore live input changes.
REQ-022 DONE SHALL last one cycle with done=1, x_valid=0 and ready=0, followed by IDLE with ready=1.
REQ-023 start asserted in the DONE cycle SHALL be ignored; start held high SHALL be accepted on the first IDLE edge.
REQ-024 Counters SHALL NOT wrap: the bit counter stops at 0 and the rep counter stops at 0.

Reset
REQ-025 clr=0 at a rising edge SHALL force IDLE, ready=1, x=0, x_valid=0 and done=0, and clear all counters and latches, in any state including mid-frame, with no done pulse.
REQ-026 While clr=0, start SHALL be ignored; the first acceptance is possible on the first edge with clr=1.

Configuration
REQ-027 Macro SEQ_TX_PARITY_EN: when defined, after bit 0 of every frame the block SHALL spend one PAR cycle with x = XOR of the transmitted bits pattern[len:0] (even parity) and x_valid=1, making frames len+2 cycles long; when undefined, there SHALL be no PAR state, frames are len+1 cycles long, and there SHALL be no parity logic.

Verification
REQ-028 Parity off, GAP=2: pattern=8'hA5, len=7, rpt=0, single start -> x = 1,0,1,0,0,1,0,1 with x_valid=1 for 8 cycles, done pulse on the 9th cycle, ready=1 on the 10th.
REQ-029 Parity off, GAP=2: pattern=8'hFF, len=2, rpt=2 -> three frames of 1,1,1 separated by exactly 2 cycles of x_valid=0; single done after the third frame.
REQ-030 GAP=0: pattern=8'h06, len=2, rpt=1 -> 1,1,0,1,1,0 back-to-back with x_valid held 1 for 6 cycles.
REQ-031 Parity on: pattern=8'h0B, len=3 -> 1,0,1,1 then parity bit 1, x_valid=1 for 5 cycles; with len=1 -> 1,1 then parity 0.
REQ-032 clr=0 asserted on the 4th SHIFT cycle -> next cycle IDLE, ready=1, x_valid=0, no done pulse; a new start is accepted on the first edge with clr=1.
REQ-033 start pulsed during SHIFT, GAP and DONE, and pattern changed mid-frame -> stream unchanged and no second transmission.
